regfile_mp: RTL and testbench
=============================

Name: regfile_mp

Overview:
- Parametrised multi-port successor of the single-cycle 2R/1W register file used by the CPU datapath.
- Provides NRD combinational read ports and two synchronous write ports (ALU/WB and load/MEM return).
- Adds optional write-through bypass and a per-register busy scoreboard so the pipeline can stall on RAW hazards without external tracking logic.
- Sits between the decode and writeback stages of the pipelined core.

Parameters:
DW, 32, data width of each register
AW, 5, address width; register count = 2**AW
NRD, 2, number of read ports (1..4)
BYPASS, 1, 1 = same-cycle write data is forwarded to matching read ports; 0 = reads return stored value only
ZERO_R0, 1, 1 = register 0 reads as zero, ignores writes and ignores issue; 0 = register 0 is an ordinary register

Ports:
clk  in  1  clock, rising edge
clr  in  1  asynchronous active-high reset
ra  in  NRD*AW  read addresses, port k at bits [k*AW +: AW]
rd  out  NRD*DW  read data, port k at bits [k*DW +: DW]
rbusy  out  NRD  busy (pending-write) flag for each read address
we0  in  1  write enable, port 0
wa0  in  AW  write address, port 0
wd0  in  DW  write data, port 0
we1  in  1  write enable, port 1 (higher priority)
wa1  in  AW  write address, port 1
wd1  in  DW  write data, port 1
iss_en  in  1  issue: mark register iss_addr busy
iss_addr  in  AW  destination register of the issued instruction
sb_flush  in  1  synchronous clear of all busy bits (pipeline flush)

Behaviour:
- Reset (clr=1, asynchronous): all 2**AW registers = 0; all busy bits = 0. rd and rbusy are combinational, so they read 0 while reset is held.
- Registers are written on the rising edge of clk only when clr=0. Reset asserted mid-write discards that write.
- Effective write j = wej && !(ZERO_R0 && waj==0).
- Both write ports target the same address with both effective: port 1 data is stored; port 0 is dropped.
- Read port k is combinational, zero added latency:
  - ZERO_R0 && ra_k==0: rd_k = 0 and rbusy_k = 0.
  - Otherwise, if BYPASS and effective write 1 matches ra_k: rd_k = wd1.
  - Otherwise, if BYPASS and effective write 0 matches ra_k: rd_k = wd0.
  - Otherwise rd_k = stored value.
- BYPASS=0: rd_k = stored value. New data appears the cycle after the write edge.
- Scoreboard busy[a], evaluated at each rising edge:
  - sb_flush=1: all busy bits <= 0. This overrides issue and writes.
  - Otherwise busy[a] <= set[a] | (busy[a] & ~clr_w[a]).
  - set[a] = iss_en && iss_addr==a && !(ZERO_R0 && a==0).
  - clr_w[a] = an effective write on either port addresses a.
  - Issue and write to the same register in the same cycle leaves busy=1: the new producer wins.
- rbusy_k:
  - BYPASS=1: rbusy_k = busy[ra_k] && !(effective write to ra_k this cycle), because forwarded data is valid now.
  - BYPASS=0: rbusy_k = busy[ra_k] | (effective write to ra_k this cycle).
  - The ZERO_R0 rule above (r0 never busy) takes precedence over both.
- Writes to a register that is not busy are legal; the data is stored and busy stays 0.
- No other timing state; there are no stall or ready outputs.
- Implementation: generate loops over NRD and 2**AW. Reset registers only with clr, no initial blocks.

Test Plan:
- Reset/zero: clr=1 during activity, then release. All ra = 0..31 -> rd=0, rbusy=0. Write we0=1, wa0=0, wd0=32'hDEAD -> ra=0 still reads 0.
- Write/read, BYPASS=1: we0=1, wa0=5, wd0=32'h1234_5678 with ra0=5 in the same cycle -> rd0=32'h12345678 that cycle and after the edge. With BYPASS=0 -> old value (0) that cycle, 32'h12345678 next cycle.
- Dual-write collision: we0=we1=1, wa0=wa1=7, wd0=32'hAAAA_AAAA, wd1=32'h5555_5555 -> ra=7 reads 32'h55555555 after the edge; with bypass, same value in the same cycle.
- Scoreboard: iss_en=1, iss_addr=9 -> ra=9 rbusy=1 next cycle. Hold 3 cycles; then we1=1, wa1=9, wd1=32'hC0DE -> rbusy=0 same cycle (BYPASS=1), busy bit 0 after the edge.
- Simultaneous issue and write to r9 while busy -> r9 stays busy. Issue to r0 -> rbusy stays 0.
- Flush/reset mid-operation: mark r3, r4, r5 busy, then sb_flush=1 together with iss_en to r6 -> all busy=0 next cycle, including r6. Assert clr asynchronously mid-cycle during we0 to r2 -> r2=0 immediately and after release.

Source files
------------

// File: rtl/regfile_mp.sv
// Multi-port register file with NRD combinational read ports, two write ports,
// optional write-through bypass and a per-register RAW busy scoreboard.
module regfile_mp #(
  parameter int DW      = 32,
  parameter int AW      = 5,
  parameter int NRD     = 2,
  parameter int BYPASS  = 1,
  parameter int ZERO_R0 = 1
) (
  input  logic              clk,
  input  logic              clr,
  input  logic [NRD*AW-1:0] ra,
  output logic [NRD*DW-1:0] rd,
  output logic [NRD-1:0]    rbusy,
  input  logic              we0,
  input  logic [AW-1:0]     wa0,
  input  logic [DW-1:0]     wd0,
  input  logic              we1,
  input  logic [AW-1:0]     wa1,
  input  logic [DW-1:0]     wd1,
  input  logic              iss_en,
  input  logic [AW-1:0]     iss_addr,
  input  logic              sb_flush
);

  localparam int NREG = 2 ** AW;
  localparam logic ZR0 = (ZERO_R0 != 0);
  localparam logic BYP = (BYPASS != 0);

  logic [DW-1:0]   mem_q [NREG];
  logic [NREG-1:0] busy_q, busy_d;
  logic            eff0, eff1;

  // Writes are suppressed while clr is held so bypass and busy views read 0 too.
  assign eff0 = we0 && !clr && !(ZR0 && (wa0 == '0));
  assign eff1 = we1 && !clr && !(ZR0 && (wa1 == '0));

  // NOTE: this storage is reset explicitly because the datapath relies on every
  // register reading 0 after reset; a plain RAM macro could not offer that.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      for (int i = 0; i < NREG; i++) mem_q[i] <= '0;
    end else begin
      if (eff0) mem_q[wa0] <= wd0;
      // Later non-blocking assignment wins, giving port 1 priority on collisions.
      if (eff1) mem_q[wa1] <= wd1;
    end
  end

  for (genvar g = 0; g < NREG; g++) begin : g_busy
    logic set_w, clr_w;
    assign set_w = iss_en && (iss_addr == AW'(g)) && !(ZR0 && (g == 0));
    assign clr_w = (eff0 && (wa0 == AW'(g))) || (eff1 && (wa1 == AW'(g)));
    // Issue beats a same-cycle write: the new producer owns the register.
    assign busy_d[g] = sb_flush ? 1'b0 : (set_w | (busy_q[g] & ~clr_w));
  end

  // NOTE: state updates use non-blocking assignments so every flop samples
  // pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) busy_q <= '0;
    else     busy_q <= busy_d;
  end

  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [AW-1:0] ra_k;
    logic          zero_k, hit0_k, hit1_k;

    assign ra_k   = ra[k*AW +: AW];
    assign zero_k = ZR0 && (ra_k == '0);
    assign hit0_k = eff0 && (wa0 == ra_k);
    assign hit1_k = eff1 && (wa1 == ra_k);

    assign rd[k*DW +: DW] = zero_k          ? '0  :
                            (BYP && hit1_k) ? wd1 :
                            (BYP && hit0_k) ? wd0 : mem_q[ra_k];

    // With bypass the in-flight write data is already usable, so it clears busy.
    assign rbusy[k] = zero_k ? 1'b0 :
                      BYP    ? (busy_q[ra_k] & ~(hit0_k | hit1_k)) :
                               (busy_q[ra_k] | hit0_k | hit1_k);
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed self-checking bench for regfile_mp: one bypass and one non-bypass
// instance share all inputs and are compared against hand-computed values.
module tb_regfile_mp;

  localparam int DW = 32;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          clr;
  logic [2*AW-1:0] ra;
  logic          we0, we1, iss_en, sb_flush;
  logic [AW-1:0] wa0, wa1, iss_addr;
  logic [DW-1:0] wd0, wd1;

  logic [2*DW-1:0] rd_b, rd_n;
  logic [1:0]      rbusy_b, rbusy_n;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  regfile_mp #(.DW(DW), .AW(AW), .NRD(2), .BYPASS(1), .ZERO_R0(1)) dut (
    .clk(clk), .clr(clr), .ra(ra), .rd(rd_b), .rbusy(rbusy_b),
    .we0(we0), .wa0(wa0), .wd0(wd0), .we1(we1), .wa1(wa1), .wd1(wd1),
    .iss_en(iss_en), .iss_addr(iss_addr), .sb_flush(sb_flush)
  );

  regfile_mp #(.DW(DW), .AW(AW), .NRD(2), .BYPASS(0), .ZERO_R0(1)) dut_nb (
    .clk(clk), .clr(clr), .ra(ra), .rd(rd_n), .rbusy(rbusy_n),
    .we0(we0), .wa0(wa0), .wd0(wd0), .we1(we1), .wa1(wa1), .wd1(wd1),
    .iss_en(iss_en), .iss_addr(iss_addr), .sb_flush(sb_flush)
  );

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    we0 = 1'b0; wa0 = '0; wd0 = '0;
    we1 = 1'b0; wa1 = '0; wd1 = '0;
    iss_en = 1'b0; iss_addr = '0; sb_flush = 1'b0;
  endtask

  task automatic set_ra(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
    ra = {a1, a0};
    #1;
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    idle();
    clr = 1'b1;
    ra  = '0;

    // Reset held during activity: nothing may be written, forwarded or marked busy.
    we0 = 1'b1; wa0 = 5'd3; wd0 = 32'h0000_00FF;
    iss_en = 1'b1; iss_addr = 5'd4;
    set_ra(5'd3, 5'd4);
    check("clr_held_rd0", rd_b[0 +: DW], 32'h0);
    check("clr_held_nb_rbusy0", {31'b0, rbusy_n[0]}, 32'h0);
    tick(); tick();
    check("clr_held_rbusy1", {31'b0, rbusy_b[1]}, 32'h0);
    idle();
    clr = 1'b0;
    tick();

    for (int a = 0; a < 32; a++) begin
      set_ra(AW'(a), AW'(31 - a));
      check($sformatf("rst_rd0_r%0d", a), rd_b[0 +: DW], 32'h0);
      check($sformatf("rst_rbusy0_r%0d", a), {31'b0, rbusy_b[0]}, 32'h0);
      check($sformatf("rst_nb_rd1_r%0d", 31 - a), rd_n[DW +: DW], 32'h0);
    end

    // Writes to r0 are ignored.
    we0 = 1'b1; wa0 = 5'd0; wd0 = 32'h0000_DEAD;
    set_ra(5'd0, 5'd0);
    check("r0_bypass_rd0", rd_b[0 +: DW], 32'h0);
    check("r0_nb_rbusy0", {31'b0, rbusy_n[0]}, 32'h0);
    tick(); idle(); #1;
    check("r0_after_rd0", rd_b[0 +: DW], 32'h0);
    check("r0_after_nb_rd0", rd_n[0 +: DW], 32'h0);

    // Single write with same-cycle read.
    we0 = 1'b1; wa0 = 5'd5; wd0 = 32'h1234_5678;
    set_ra(5'd5, 5'd0);
    check("wr5_byp_rd0", rd_b[0 +: DW], 32'h1234_5678);
    check("wr5_byp_rbusy0", {31'b0, rbusy_b[0]}, 32'h0);
    check("wr5_nb_rd0", rd_n[0 +: DW], 32'h0);
    check("wr5_nb_rbusy0", {31'b0, rbusy_n[0]}, 32'h1);
    tick(); idle(); #1;
    check("wr5_after_rd0", rd_b[0 +: DW], 32'h1234_5678);
    check("wr5_after_nb_rd0", rd_n[0 +: DW], 32'h1234_5678);
    check("wr5_after_nb_rbusy0", {31'b0, rbusy_n[0]}, 32'h0);

    // Dual write to the same address: port 1 wins.
    we0 = 1'b1; wa0 = 5'd7; wd0 = 32'hAAAA_AAAA;
    we1 = 1'b1; wa1 = 5'd7; wd1 = 32'h5555_5555;
    set_ra(5'd0, 5'd7);
    check("coll_byp_rd1", rd_b[DW +: DW], 32'h5555_5555);
    check("coll_nb_rd1", rd_n[DW +: DW], 32'h0);
    tick(); idle(); #1;
    check("coll_after_rd1", rd_b[DW +: DW], 32'h5555_5555);
    check("coll_after_nb_rd1", rd_n[DW +: DW], 32'h5555_5555);

    // Dual write to different addresses: both land.
    we0 = 1'b1; wa0 = 5'd10; wd0 = 32'h0000_0111;
    we1 = 1'b1; wa1 = 5'd11; wd1 = 32'h0000_0222;
    set_ra(5'd10, 5'd11);
    check("dual_byp_rd0", rd_b[0 +: DW], 32'h0000_0111);
    check("dual_byp_rd1", rd_b[DW +: DW], 32'h0000_0222);
    tick(); idle(); #1;
    check("dual_after_nb_rd0", rd_n[0 +: DW], 32'h0000_0111);
    check("dual_after_nb_rd1", rd_n[DW +: DW], 32'h0000_0222);

    // Scoreboard: issue r9, hold, then clear with a port-1 write.
    iss_en = 1'b1; iss_addr = 5'd9;
    set_ra(5'd9, 5'd5);
    check("iss9_same_rbusy0", {31'b0, rbusy_b[0]}, 32'h0);
    tick(); idle(); #1;
    for (int c = 0; c < 3; c++) begin
      check($sformatf("busy9_hold%0d", c), {31'b0, rbusy_b[0]}, 32'h1);
      check($sformatf("busy9_nb_hold%0d", c), {31'b0, rbusy_n[0]}, 32'h1);
      check($sformatf("busy5_idle%0d", c), {31'b0, rbusy_b[1]}, 32'h0);
      tick();
    end
    we1 = 1'b1; wa1 = 5'd9; wd1 = 32'h0000_C0DE;
    #1;
    check("wb9_byp_rbusy0", {31'b0, rbusy_b[0]}, 32'h0);
    check("wb9_byp_rd0", rd_b[0 +: DW], 32'h0000_C0DE);
    check("wb9_nb_rbusy0", {31'b0, rbusy_n[0]}, 32'h1);
    check("wb9_nb_rd0", rd_n[0 +: DW], 32'h0);
    tick(); idle(); #1;
    check("wb9_after_rbusy0", {31'b0, rbusy_b[0]}, 32'h0);
    check("wb9_after_nb_rbusy0", {31'b0, rbusy_n[0]}, 32'h0);
    check("wb9_after_nb_rd0", rd_n[0 +: DW], 32'h0000_C0DE);

    // Issue and write to busy r9 in the same cycle: r9 stays busy.
    iss_en = 1'b1; iss_addr = 5'd9;
    tick(); #1;
    we0 = 1'b1; wa0 = 5'd9; wd0 = 32'h0000_BEEF;
    #1;
    check("isswr9_byp_rbusy0", {31'b0, rbusy_b[0]}, 32'h0);
    check("isswr9_nb_rbusy0", {31'b0, rbusy_n[0]}, 32'h1);
    tick(); idle(); #1;
    check("isswr9_after_rbusy0", {31'b0, rbusy_b[0]}, 32'h1);
    check("isswr9_after_rd0", rd_b[0 +: DW], 32'h0000_BEEF);

    // Issue to r0 never marks it busy.
    iss_en = 1'b1; iss_addr = 5'd0;
    set_ra(5'd9, 5'd0);
    tick(); idle(); #1;
    check("iss0_rbusy1", {31'b0, rbusy_b[1]}, 32'h0);
    check("iss0_nb_rbusy1", {31'b0, rbusy_n[1]}, 32'h0);

    // Flush: r3, r4, r5 busy (r9 still busy), flush with issue to r6 clears all.
    for (int r = 3; r <= 5; r++) begin
      iss_en = 1'b1; iss_addr = AW'(r);
      tick();
    end
    idle();
    set_ra(5'd3, 5'd5);
    check("pre_flush_r3", {31'b0, rbusy_b[0]}, 32'h1);
    check("pre_flush_r5", {31'b0, rbusy_b[1]}, 32'h1);
    set_ra(5'd4, 5'd9);
    check("pre_flush_r4", {31'b0, rbusy_b[0]}, 32'h1);
    check("pre_flush_r9", {31'b0, rbusy_b[1]}, 32'h1);
    sb_flush = 1'b1; iss_en = 1'b1; iss_addr = 5'd6;
    tick(); idle(); #1;
    for (int r = 3; r <= 6; r++) begin
      set_ra(AW'(r), 5'd9);
      check($sformatf("flush_r%0d", r), {31'b0, rbusy_b[0]}, 32'h0);
      check($sformatf("flush_nb_r%0d", r), {31'b0, rbusy_n[0]}, 32'h0);
    end
    check("flush_r9", {31'b0, rbusy_b[1]}, 32'h0);

    // Async clear mid-cycle during a write to r2.
    we0 = 1'b1; wa0 = 5'd2; wd0 = 32'h0000_0077;
    tick(); idle(); #1;
    set_ra(5'd2, 5'd5);
    check("r2_pre_rd0", rd_b[0 +: DW], 32'h0000_0077);
    we0 = 1'b1; wa0 = 5'd2; wd0 = 32'h0000_0099;
    #1;
    check("r2_wr_byp_rd0", rd_b[0 +: DW], 32'h0000_0099);
    #1;
    clr = 1'b1;
    #1;
    check("clr_mid_rd0", rd_b[0 +: DW], 32'h0);
    check("clr_mid_nb_rd0", rd_n[0 +: DW], 32'h0);
    check("clr_mid_rd1", rd_b[DW +: DW], 32'h0);
    tick();
    @(negedge clk);
    idle();
    clr = 1'b0;
    #1;
    check("clr_rel_rd0", rd_b[0 +: DW], 32'h0);
    tick();
    check("clr_rel_after_rd0", rd_b[0 +: DW], 32'h0);
    check("clr_rel_after_nb_rd0", rd_n[0 +: DW], 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
